// File: rtl/temporizador_mmss_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
//   estado_t      : control FSM state encoding
//   DIGITO_MAX    : largest BCD digit value
//   DECENA_SEG_MAX: largest tens digit for seconds
//   CERO_MMSS     : packed {min, seg} value for 00:00
//   bcd_valido()  : checks a packed two-digit BCD value against a tens limit
package temporizador_mmss_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSA    = 2'd2,
    ALARMA   = 2'd3
  } estado_t;

  localparam int unsigned ANCHO_BCD2 = 8;
  localparam int unsigned ANCHO_MMSS = 16;

  localparam logic [3:0] DIGITO_MAX     = 4'd9;
  localparam logic [3:0] DECENA_SEG_MAX = 4'd5;
  localparam logic [ANCHO_MMSS-1:0] CERO_MMSS = 16'h0000;

  // True when both digits are legal BCD and the tens digit is within limite.
  function automatic logic bcd_valido(input logic [ANCHO_BCD2-1:0] valor,
                                      input logic [3:0] limite);
    return (valor[7:4] <= limite) && (valor[3:0] <= DIGITO_MAX);
  endfunction

endpackage

// File: rtl/temporizador_mmss_decrementador_bcd2.sv
// Combinational decrement of a packed two-digit BCD value.
//   valor        : current value {tens, units}
//   limite       : tens digit used when wrapping 00 -> {limite, 9}
//   siguiente_c  : value minus one
//   prestamo_c   : set when valor was 00 (borrow out to the next field)
module decrementador_bcd2
  import temporizador_mmss_pkg::*;
(
  input  logic [ANCHO_BCD2-1:0] valor,
  input  logic [3:0]            limite,
  output logic [ANCHO_BCD2-1:0] siguiente_c,
  output logic                  prestamo_c
);

  always_comb begin
    siguiente_c = valor;
    prestamo_c  = 1'b0;
    if (valor[3:0] != 4'd0) begin
      siguiente_c[3:0] = valor[3:0] - 4'd1;
    end else begin
      // units wrap to 9; tens either drop by one or wrap to the limit
      siguiente_c[3:0] = DIGITO_MAX;
      if (valor[7:4] != 4'd0) begin
        siguiente_c[7:4] = valor[7:4] - 4'd1;
      end else begin
        siguiente_c[7:4] = limite;
        prestamo_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/temporizador_mmss.sv
// Programmable mm:ss BCD countdown timer driven by a 1 Hz tick strobe.
//   clock, reset        : clock and synchronous active-high reset
//   tick                : one-cycle 1 Hz strobe
//   load, start, stop   : one-cycle control requests (stop > load > start)
//   carga_min/carga_seg : packed BCD value to load
//   min_bcd/seg_bcd     : current time, packed BCD
//   contando            : high while counting down
//   alarma              : high while the expiry alarm is active
//   carga_err           : one-cycle pulse when a load is rejected
module temporizador_mmss
  import temporizador_mmss_pkg::*;
#(
  parameter int unsigned ALARMA_TICKS = 3,
  parameter int unsigned ANCHO_ALARMA = 8
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  load,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ANCHO_BCD2-1:0] carga_min,
  input  logic [ANCHO_BCD2-1:0] carga_seg,
  output logic [ANCHO_BCD2-1:0] min_bcd,
  output logic [ANCHO_BCD2-1:0] seg_bcd,
  output logic                  contando,
  output logic                  alarma,
  output logic                  carga_err
);

  estado_t                 estado;
  logic [ANCHO_ALARMA-1:0] cnt_alarma;

  logic [ANCHO_BCD2-1:0] seg_dec_c, min_dec_c, min_sig_c;
  logic                  prestamo_seg_c, prestamo_min_c;
  logic                  desborde_c, llega_cero_c, tiempo_cero_c, carga_valida_c;
  logic [ANCHO_ALARMA-1:0] cnt_inc_c;

  decrementador_bcd2 u_dec_seg (
    .valor       (seg_bcd),
    .limite      (DECENA_SEG_MAX),
    .siguiente_c (seg_dec_c),
    .prestamo_c  (prestamo_seg_c)
  );

  decrementador_bcd2 u_dec_min (
    .valor       (min_bcd),
    .limite      (DIGITO_MAX),
    .siguiente_c (min_dec_c),
    .prestamo_c  (prestamo_min_c)
  );

  // Minutes only move when seconds borrow; both borrowing means 00:00.
  assign min_sig_c      = prestamo_seg_c ? min_dec_c : min_bcd;
  assign desborde_c     = prestamo_seg_c & prestamo_min_c;
  assign llega_cero_c   = ({min_sig_c, seg_dec_c} == CERO_MMSS);
  assign tiempo_cero_c  = ({min_bcd, seg_bcd} == CERO_MMSS);
  assign carga_valida_c = bcd_valido(carga_min, DIGITO_MAX) &&
                          bcd_valido(carga_seg, DECENA_SEG_MAX);
  assign cnt_inc_c      = cnt_alarma + ANCHO_ALARMA'(1);

  // Control FSM with registered display, status and alarm counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= PARADO;
      min_bcd    <= 8'h00;
      seg_bcd    <= 8'h00;
      contando   <= 1'b0;
      alarma     <= 1'b0;
      carga_err  <= 1'b0;
      cnt_alarma <= '0;
    end else begin
      carga_err <= 1'b0;
      case (estado)
        PARADO, PAUSA: begin
          if (stop) begin
            if (estado == PAUSA) begin
              estado  <= PARADO;
              min_bcd <= 8'h00;
              seg_bcd <= 8'h00;
            end
          end else if (load) begin
            if (carga_valida_c) begin
              min_bcd <= carga_min;
              seg_bcd <= carga_seg;
            end else begin
              carga_err <= 1'b1;
            end
          end else if (start && !tiempo_cero_c) begin
            estado   <= CONTANDO;
            contando <= 1'b1;
          end
        end
        CONTANDO: begin
          if (stop) begin
            estado   <= PAUSA;
            contando <= 1'b0;
          end else if (tick && !desborde_c) begin
            min_bcd <= min_sig_c;
            seg_bcd <= seg_dec_c;
            if (llega_cero_c) begin
              estado     <= ALARMA;
              contando   <= 1'b0;
              alarma     <= 1'b1;
              cnt_alarma <= '0;
            end
          end
        end
        ALARMA: begin
          if (stop) begin
            estado <= PARADO;
            alarma <= 1'b0;
          end else if (tick) begin
            cnt_alarma <= cnt_inc_c;
            if (cnt_inc_c == ANCHO_ALARMA'(ALARMA_TICKS)) begin
              estado <= PARADO;
              alarma <= 1'b0;
            end
          end
        end
        default: begin
          estado   <= PARADO;
          contando <= 1'b0;
          alarma   <= 1'b0;
        end
      endcase
    end
  end

endmodule
